// File: rtl/apx_err_monitor_pkg.sv
// Shared definitions for the approximate-adder error monitor and its stage-1 helper.
package apx_mon_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_ACC_W = 48;

    // Ceiling of the summed-error accumulator at the default width.
    localparam logic [DEF_ACC_W-1:0] SUM_SAT_DEF = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/apx_err_monitor_if.sv
// Result-pair stream: the producer drives a pair plus valid, the monitor answers with ready.
interface apx_sample_if
    import apx_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_acc;
    logic [WIDTH-1:0] in_apx;

    modport master (output in_valid, output in_acc, output in_apx, input in_ready);
    modport slave  (input in_valid, input in_acc, input in_apx, output in_ready);

endinterface

// File: rtl/apx_err_dist.sv
// Registered error-distance stage: |acc - apx| via a WIDTH+1 difference, plus nonzero flag.
module apx_err_dist
    import apx_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_acc,
    input  logic [WIDTH-1:0] in_apx,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_ed,
    output logic             out_nz
);

    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] mag;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] ed_d, ed_q;
    logic             nz_d, nz_q;

    // Magnitude of the sign-extended difference; ED is held when no new pair arrives.
    always_comb begin
        diff    = {1'b0, in_acc} - {1'b0, in_apx};
        mag     = diff[WIDTH] ? (~diff[WIDTH-1:0] + WIDTH'(1)) : diff[WIDTH-1:0];
        valid_d = in_valid;
        ed_d    = in_valid ? mag : ed_q;
        nz_d    = in_valid ? (mag != '0) : nz_q;
    end

    // Stage-1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ed_q    <= '0;
            nz_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ed_q    <= ed_d;
            nz_q    <= nz_d;
        end
    end

    assign out_valid = valid_q;
    assign out_ed    = ed_q;
    assign out_nz    = nz_q;

endmodule

// File: rtl/apx_err_monitor.sv
// Error-statistics collector: accepts result pairs, accumulates ED stats over one run.
//
// state    | meaning
// IDLE     | after reset, waiting for start; stats zero
// RUN      | accepting pairs until num_samples have been taken
// DRAIN    | last pair is in stage 1; stats final on the next edge
// DONE     | stats frozen and readable; start begins a new run
module apx_err_monitor
    import apx_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    apx_sample_if.slave       smp,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  samples_seen,
    output logic [CNT_W-1:0]  err_count,
    output logic [WIDTH-1:0]  max_ed,
    output logic [ACC_W-1:0]  sum_ed
);

    localparam logic [ACC_W-1:0] SAT_MAX = '1;

    mon_state_e       state_d, state_q;
    logic [CNT_W-1:0] num_d, num_q;
    logic [CNT_W-1:0] accepted_d, accepted_q;
    logic             in_ready_d, in_ready_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic [CNT_W-1:0] seen_d, seen_q;
    logic [CNT_W-1:0] err_d, err_q;
    logic [WIDTH-1:0] max_d, max_q;
    logic [ACC_W-1:0] sum_d, sum_q;
    logic [ACC_W:0]   sum_ext;

    logic             xfer;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_ed;
    logic             s1_nz;

    assign xfer = smp.in_valid && in_ready_q;

    apx_err_dist #(.WIDTH(WIDTH)) u_dist (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (xfer),
        .in_acc    (smp.in_acc),
        .in_apx    (smp.in_apx),
        .out_valid (s1_valid),
        .out_ed    (s1_ed),
        .out_nz    (s1_nz)
    );

    // Next-state for the FSM, acceptance counter and stage-2 statistics.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        accepted_d = accepted_q;
        seen_d     = seen_q;
        err_d      = err_q;
        max_d      = max_q;
        sum_d      = sum_q;
        sum_ext    = {1'b0, sum_q} + {{(ACC_W + 1 - WIDTH){1'b0}}, s1_ed};

        if (s1_valid) begin
            seen_d = seen_q + CNT_W'(1);
            err_d  = err_q + CNT_W'(s1_nz);
            if (s1_ed > max_q) begin
                max_d = s1_ed;
            end
            sum_d  = sum_ext[ACC_W] ? SAT_MAX : sum_ext[ACC_W-1:0];
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    num_d      = num_samples;
                    accepted_d = '0;
                    seen_d     = '0;
                    err_d      = '0;
                    max_d      = '0;
                    sum_d      = '0;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    accepted_d = accepted_q + CNT_W'(1);
                end
                if (num_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (xfer && (accepted_q == num_q - CNT_W'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Nothing enters stage 1 here, so the last sample retires on this edge.
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_RUN) && (accepted_d < num_d);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    // State, control outputs and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            accepted_q <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seen_q     <= '0;
            err_q      <= '0;
            max_q      <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            accepted_q <= accepted_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            seen_q     <= seen_d;
            err_q      <= err_d;
            max_q      <= max_d;
            sum_q      <= sum_d;
        end
    end

    assign smp.in_ready  = in_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign samples_seen  = seen_q;
    assign err_count     = err_q;
    assign max_ed        = max_q;
    assign sum_ed        = sum_q;

endmodule

// File: doc/apx_err_monitor.md
Name: apx_err_monitor

Overview:
- Streaming error-statistics collector for the approximate integer adders.
- Consumes one (accurate, approximate) result pair per handshake, e.g. acc_adder output against a bta / bta_trunc output for the same operands.
- Accumulates error metrics over a programmed number of samples: error distance, maximum error, erroneous-sample count.
- Replaces file logging with an in-hardware measurement; results stay readable until the next run.

Parameters:
- WIDTH, 32, width of the result words being compared
- CNT_W, 16, width of the sample counters and of num_samples
- ACC_W, 48, width of the summed-error-distance accumulator

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  one-cycle pulse; clears stats and begins a run (honoured only in IDLE/DONE)
- num_samples  input  CNT_W  samples per run, sampled on start
- in_valid  input  1  result pair valid
- in_ready  output  1  block can accept a pair
- in_acc  input  WIDTH  accurate adder result
- in_apx  input  WIDTH  approximate adder result
- busy  output  1  high in RUN and DRAIN
- done  output  1  level, high in DONE
- samples_seen  output  CNT_W  accepted pairs in current/last run
- err_count  output  CNT_W  pairs with in_acc != in_apx
- max_ed  output  WIDTH  largest error distance seen
- sum_ed  output  ACC_W  saturating sum of error distances

Behaviour:
- Reset: state IDLE; all outputs 0 (in_ready, busy, done, all stats); pipeline valid bits cleared.
  - Reset mid-run aborts the run immediately; no partial stats are retained.
- Error distance: ED = |in_acc - in_apx|.
  - Both operands unsigned; the difference is computed at WIDTH+1 bits, then its magnitude is taken.
  - ED fits in WIDTH bits.
- Handshake: transfer when in_valid && in_ready.
  - in_ready = 1 only in RUN and only while accepted < num_samples.
  - in_acc/in_apx are don't-care when no transfer occurs.
- Pipeline, 2 stages:
  - Stage 1 registers ED and its nonzero flag at the transfer edge.
  - Stage 2 updates the stats on the next edge.
  - A transfer in cycle k is reflected in the stats outputs after edge k+2.
  - Throughput: 1 pair/cycle.
- Stats update per stage-2 sample:
  - samples_seen += 1.
  - err_count += (ED != 0).
  - max_ed = max(max_ed, ED).
  - sum_ed = min(sum_ed + ED, 2^ACC_W - 1), i.e. saturating; it never wraps.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --start--> RUN: clear all stats, latch num_samples, accepted counter = 0, done = 0.
  - If the latched num_samples = 0, go RUN -> DRAIN on the next edge with no transfers.
  - RUN -> DRAIN on the edge of the transfer that makes accepted == num_samples. in_ready drops in the same edge, so no over-acceptance occurs.
  - DRAIN -> DONE once both pipeline stages are empty (2 cycles after the last transfer). Stats are final when done rises.
  - DONE holds all stats until the next start.
- start while busy is ignored; the run continues unchanged.
- in_valid asserted while not in RUN: no transfer, no effect.
- Counters never wrap: accepted is bounded by num_samples ≤ 2^CNT_W - 1.

Decomposition:
- Shared package apx_mon_pkg holds:
  - FSM state enum (IDLE, RUN, DRAIN, DONE)
  - default WIDTH/CNT_W/ACC_W constants
  - saturation limit constant
- One sub-module, apx_err_dist: registered stage 1. Computes WIDTH+1 difference, magnitude, and nonzero flag, with a valid bit. Reused by other adder-evaluation blocks.
- Accumulation and FSM stay in apx_err_monitor.

Test Plan:
- Reset check: assert rst_n=0 during RUN after 3 transfers -> all outputs 0 immediately (asynchronous); after release, state IDLE, in_ready=0.
- Exact match: start, num_samples=4, pairs all acc=apx=0x0000_1234 on back-to-back cycles -> done after last transfer +2 cycles; samples_seen=4, err_count=0, max_ed=0, sum_ed=0.
- Mixed errors, with stalls (in_valid gaps of 1–3 cycles):
  - pairs (0x10,0x0F), (0x0F,0x10), (0x100,0x100), (0xFFFF_FFFF,0x0000_0000)
  - required: err_count=3, max_ed=0xFFFF_FFFF, sum_ed=0x1_0000_0001
- Saturation: ACC_W=33, three pairs with ED=0xFFFF_FFFF -> sum_ed=0x1_FFFF_FFFF (saturated), samples_seen=3.
- Boundaries:
  - num_samples=0 -> in_ready never high; done within 3 cycles with all stats 0.
  - start pulsed mid-run -> ignored, run finishes with original count.
  - in_valid held high after the last transfer -> no extra sample counted.
- Restart: from DONE with stats non-zero, start with num_samples=1, pair (5,3) -> stats cleared on start; final samples_seen=1, err_count=1, max_ed=2, sum_ed=2.
